// File: rtl/clk_to_duty_pkg.sv
// Shared types and default widths for the clk_to_duty PWM duty decoder.
package clk_to_duty_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int DUTY_W_DEF = 12;

  typedef enum logic {IDLE, MEAS} state_e;
  typedef enum logic {DIV_IDLE, DIV_RUN} div_state_e;

endpackage

// File: rtl/clk_to_duty_if.sv
// Result port of clk_to_duty: duty code plus status, with a valid/ready handshake.
interface clk_to_duty_if
  import clk_to_duty_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF
);

  // A result transfers on any cycle where duty_valid && duty_ready. duty_valid
  // holds until then; duty_out may be replaced by a newer result (overrun pulse).
  logic [DUTY_W-1:0] duty_out;
  logic              duty_valid;
  logic              duty_ready;
  logic              overrun;
  logic              stuck;

  modport master (output duty_out, duty_valid, overrun, stuck, input duty_ready);
  modport slave  (input duty_out, duty_valid, overrun, stuck, output duty_ready);

endinterface

// File: rtl/clk_to_duty_div.sv
// duty_div: sequential restoring divider, quot = floor(hi * 2^DUTY_W / per).
// Assumes hi < per, so only the DUTY_W fractional quotient bits are produced.
module duty_div
  import clk_to_duty_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DUTY_W = DUTY_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  hi,
  input  logic [CNT_W-1:0]  per,
  output logic              busy,
  output logic              done,
  output logic [DUTY_W-1:0] quot,
  output div_state_e        dbg_state
);

  localparam int IW = $clog2(DUTY_W);
  localparam logic [IW-1:0] LAST = IW'(DUTY_W - 1);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  den_q, den_d;
  logic [DUTY_W-1:0] quot_q, quot_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [CNT_W:0]    sh;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    den_d   = den_q;
    quot_d  = quot_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    sh      = {rem_q, 1'b0};
    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          rem_d   = hi;
          den_d   = per;
          quot_d  = '0;
          cnt_d   = '0;
          state_d = DIV_RUN;
        end
      end
      DIV_RUN: begin
        // Remainder stays below den, so both branches fit back in CNT_W bits.
        if (sh >= {1'b0, den_q}) begin
          rem_d  = sh[CNT_W-1:0] - den_q;
          quot_d = {quot_q[DUTY_W-2:0], 1'b1};
        end else begin
          rem_d  = sh[CNT_W-1:0];
          quot_d = {quot_q[DUTY_W-2:0], 1'b0};
        end
        if (cnt_q == LAST) begin
          state_d = DIV_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
      rem_q   <= '0;
      den_q   <= '0;
      quot_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      den_q   <= den_d;
      quot_q  <= quot_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q == DIV_RUN);
  assign done      = done_q;
  assign quot      = quot_q;
  assign dbg_state = state_q;

endmodule

// File: rtl/clk_to_duty.sv
// clk_to_duty: measures PWM period/high time and reports duty = hi*2^DUTY_W/per.
// Optional output clamping to [DUTY_LO, DUTY_HI] is enabled by CLK_TO_DUTY_CLAMP_EN.
module clk_to_duty
  import clk_to_duty_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DUTY_W  = DUTY_W_DEF,
  parameter int DUTY_LO = 205,
  parameter int DUTY_HI = 3686
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pwm_in,
  clk_to_duty_if.master bus,
  output state_e        dbg_state,
  output div_state_e    dbg_div_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (DUTY_LO >= DUTY_HI || DUTY_HI >= (1 << DUTY_W)) begin : g_bad_clamp
    $error("clk_to_duty: clamp range needs DUTY_LO < DUTY_HI < 2**DUTY_W");
  end

  logic              sync1_q, sync1_d, s_in_q, s_in_d, s_prev_q, s_prev_d;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d;
  logic [DUTY_W-1:0] duty_out_q, duty_out_d;
  logic              valid_q, valid_d, overrun_q, overrun_d, stuck_q, stuck_d;
  logic              rise, div_start, timeout, div_busy, div_done;
  logic [DUTY_W-1:0] div_quot, res_raw, res_val;

  duty_div #(.CNT_W(CNT_W), .DUTY_W(DUTY_W)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .hi        (hi_cnt_q),
    .per       (per_cnt_q),
    .busy      (div_busy),
    .done      (div_done),
    .quot      (div_quot),
    .dbg_state (dbg_div_state)
  );

  always_comb begin
    sync1_d   = pwm_in;
    s_in_d    = sync1_q;
    s_prev_d  = s_in_q;
    rise      = s_in_q & ~s_prev_q;
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    div_start = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          per_cnt_d = CNT_W'(1);
          hi_cnt_d  = CNT_W'(1);
          state_d   = MEAS;
        end
      end
      MEAS: begin
        // A rise while the divider is busy restarts the counters but loses that period.
        if (rise) begin
          per_cnt_d = CNT_W'(1);
          hi_cnt_d  = CNT_W'(1);
          div_start = ~div_busy;
        end else if (per_cnt_q == CNT_MAX) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          per_cnt_d = per_cnt_q + CNT_W'(1);
          hi_cnt_d  = hi_cnt_q + CNT_W'(s_in_q);
        end
      end
    endcase

    res_raw = timeout ? {DUTY_W{s_in_q}} : div_quot;
`ifdef CLK_TO_DUTY_CLAMP_EN
    if (res_raw < DUTY_W'(DUTY_LO))      res_val = DUTY_W'(DUTY_LO);
    else if (res_raw > DUTY_W'(DUTY_HI)) res_val = DUTY_W'(DUTY_HI);
    else                                 res_val = res_raw;
`else
    res_val = res_raw;
`endif

    duty_out_d = duty_out_q;
    valid_d    = valid_q;
    overrun_d  = 1'b0;
    stuck_d    = stuck_q;
    // A fresh result beats a same-cycle handshake; it only overruns if nobody took the old one.
    if (timeout || div_done) begin
      duty_out_d = res_val;
      valid_d    = 1'b1;
      overrun_d  = valid_q & ~bus.duty_ready;
      stuck_d    = timeout;
    end else if (valid_q && bus.duty_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      s_in_q     <= 1'b0;
      s_prev_q   <= 1'b0;
      state_q    <= IDLE;
      per_cnt_q  <= '0;
      hi_cnt_q   <= '0;
      duty_out_q <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      stuck_q    <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      s_in_q     <= s_in_d;
      s_prev_q   <= s_prev_d;
      state_q    <= state_d;
      per_cnt_q  <= per_cnt_d;
      hi_cnt_q   <= hi_cnt_d;
      duty_out_q <= duty_out_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      stuck_q    <= stuck_d;
    end
  end

  assign bus.duty_out   = duty_out_q;
  assign bus.duty_valid = valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.stuck      = stuck_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_clk_to_duty.sv
// Directed bench for clk_to_duty: vector table of PWM operating points plus
// hand sequences for backpressure, reset mid-division and the stuck-high timeout.
module tb_clk_to_duty;
  import clk_to_duty_pkg::*;

  localparam int DW = 12;

  typedef struct {
    int             per;
    int             hi;
    int             n;
    logic [DW-1:0]  exp_raw;
    logic [DW-1:0]  exp_clamp;
  } vec_t;

`ifdef CLK_TO_DUTY_CLAMP_EN
  localparam logic [DW-1:0] STUCK_EXP = 12'd3686;
`else
  localparam logic [DW-1:0] STUCK_EXP = 12'd4095;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       pwm_in = 1'b0;
  state_e     dbg_state;
  div_state_e dbg_div_state;

  clk_to_duty_if #(.DUTY_W(DW)) bus ();

  clk_to_duty dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pwm_in        (pwm_in),
    .bus           (bus),
    .dbg_state     (dbg_state),
    .dbg_div_state (dbg_div_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int            total   = 0;
  int            bad     = 0;
  int            res_cnt = 0;
  int            ovr_cnt = 0;
  logic [DW:0]   exp_q[$];       // {stuck, duty_out} per accepted result
  bit            push_en = 1'b1;
  bit            prev_ok = 1'b0;
  logic [DW-1:0] prev_exp = '0;
  vec_t          vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 'h%0h want 'h%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    pwm_in  = 1'b0;
    prev_ok = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------- driver ----------------
  // A rise closes the running period: its expected code is queued then.
  task automatic rise_push(input logic [DW-1:0] nxt, input bit nxt_ok);
    pwm_in = 1'b1;
    if (prev_ok && push_en) exp_q.push_back({1'b0, prev_exp});
    prev_exp = nxt;
    prev_ok  = nxt_ok;
  endtask

  task automatic pwm_period(input int per, input int hi, input logic [DW-1:0] exp);
    rise_push(exp, 1'b1);
    repeat (hi) tick();
    pwm_in = 1'b0;
    repeat (per - hi) tick();
  endtask

  task automatic close_period();
    rise_push('0, 1'b0);
    repeat (20) tick();
    pwm_in = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: got %0d results pending want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic logic [DW-1:0] pick(input vec_t v);
`ifdef CLK_TO_DUTY_CLAMP_EN
    return v.exp_clamp;
`else
    return v.exp_raw;
`endif
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.overrun) ovr_cnt++;
      if (bus.duty_valid && bus.duty_ready) begin
        res_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got duty %0d stuck %0d want none",
                   bus.duty_out, bus.stuck);
        end else begin
          check("result", {bus.stuck, bus.duty_out}, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int r0;
    int o0;
    bus.duty_ready = 1'b1;

    vecs[0] = '{1000, 250, 2, 12'd1024, 12'd1024};
    vecs[1] = '{ 400, 100, 2, 12'd1024, 12'd1024};
    vecs[2] = '{1000, 500, 2, 12'd2048, 12'd2048};
    vecs[3] = '{ 100,  33, 2, 12'd1351, 12'd1351};
    vecs[4] = '{  14,   7, 3, 12'd2048, 12'd2048};
    vecs[5] = '{ 100,  99, 2, 12'd4055, 12'd3686};
    vecs[6] = '{ 100,   1, 2, 12'd40,   12'd205};
    vecs[7] = '{1000,  20, 2, 12'd81,   12'd205};
    vecs[8] = '{1000, 950, 2, 12'd3891, 12'd3686};

    do_reset();
    check("rst_duty_out", bus.duty_out, 0);
    check("rst_duty_valid", bus.duty_valid, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_stuck", bus.stuck, 0);
    check("rst_state", dbg_state, IDLE);
    check("rst_div_state", dbg_div_state, DIV_IDLE);

    // Operating-point table, ready always high.
    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        pwm_period(vecs[i].per, vecs[i].hi, pick(vecs[i]));
        if (i == 0 && k == 0) check("meas_state", dbg_state, MEAS);
      end
    end
    close_period();
    drain("table_drain");
    check("table_result_count", res_cnt, 19);
    check("table_overrun_count", ovr_cnt, 0);

    // Backpressure: two results with ready low, the second overwrites.
    do_reset();
    push_en = 1'b0;
    bus.duty_ready = 1'b0;
    r0 = res_cnt;
    o0 = ovr_cnt;
    pwm_period(1000, 300, 12'd1228);
    pwm_in = 1'b1;
    repeat (100) tick();
    check("bp_first_duty", bus.duty_out, 1228);
    check("bp_first_overrun", ovr_cnt - o0, 0);
    repeat (500) tick();
    pwm_in = 1'b0;
    repeat (400) tick();
    pwm_in = 1'b1;
    repeat (30) tick();
    pwm_in = 1'b0;
    check("bp_overrun_count", ovr_cnt - o0, 1);
    check("bp_duty_out", bus.duty_out, 2457);
    check("bp_valid_held", bus.duty_valid, 1);
    exp_q.push_back({1'b0, 12'd2457});
    bus.duty_ready = 1'b1;
    tick();
    check("bp_valid_cleared", bus.duty_valid, 0);
    check("bp_result_count", res_cnt - r0, 1);
    push_en = 1'b1;

    // Reset mid-division with a held result, then restart latency.
    do_reset();
    push_en = 1'b0;
    bus.duty_ready = 1'b0;
    pwm_period(200, 50, 12'd1024);
    pwm_period(200, 50, 12'd1024);
    pwm_in = 1'b1;
    repeat (7) tick();
    check("pre_rst_duty", bus.duty_out, 1024);
    check("pre_rst_valid", bus.duty_valid, 1);
    check("pre_rst_div_run", dbg_div_state, DIV_RUN);
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    #1;
    check("mid_rst_duty", bus.duty_out, 0);
    check("mid_rst_valid", bus.duty_valid, 0);
    check("mid_rst_overrun", bus.overrun, 0);
    check("mid_rst_stuck", bus.stuck, 0);
    check("mid_rst_state", dbg_state, IDLE);
    check("mid_rst_div_state", dbg_div_state, DIV_IDLE);
    tick();
    tick();
    rst_n   = 1'b1;
    prev_ok = 1'b0;
    push_en = 1'b1;
    bus.duty_ready = 1'b1;
    repeat (5) tick();
    pwm_period(200, 50, 12'd1024);
    rise_push('0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) check("lat_valid_early", bus.duty_valid, 0);
      if (k == 16) begin
        check("lat_valid", bus.duty_valid, 1);
        check("lat_duty", bus.duty_out, 1024);
      end
    end
    repeat (30) tick();
    pwm_in = 1'b0;
    drain("reset_drain");

    // Stuck high: one timeout result, then normal pulses clear stuck.
    do_reset();
    pwm_period(100, 25, 12'd1024);
    pwm_period(100, 25, 12'd1024);
    rise_push('0, 1'b0);
    exp_q.push_back({1'b1, STUCK_EXP});
    repeat (100) tick();
    r0 = res_cnt;
    repeat (65900) tick();
    check("stuck_result_count", res_cnt - r0, 1);
    check("stuck_flag", bus.stuck, 1);
    check("stuck_duty", bus.duty_out, STUCK_EXP);
    check("stuck_state", dbg_state, IDLE);
    pwm_in = 1'b0;
    repeat (50) tick();
    check("stuck_fall_state", dbg_state, IDLE);
    pwm_period(1000, 250, 12'd1024);
    close_period();
    drain("stuck_drain");
    check("stuck_cleared", bus.stuck, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_to_duty.md
# clk_to_duty

Digital PWM duty-cycle decoder: it measures the high time and period of an incoming pulse-width-modulated clock and reports the duty as an unsigned fixed-point fraction. It is the receiving end of the duty-to-clock path: a `duty_to_clk`-style generator produces the pulse train, and this block recovers the duty for digital control and monitoring loops. It sits in the synchronous `clk` domain and samples the asynchronous `pwm_in`.

## Interface
- `CNT_W`, 16: width of the period and high counters, in `clk` cycles.
- `DUTY_W`, 12: width of the duty result; value = `duty_out` / 2^`DUTY_W`.
- `DUTY_LO`, 205: lower clamp code (about 0.05). Used only with the clamp macro.
- `DUTY_HI`, 3686: upper clamp code (about 0.9). Used only with the clamp macro.
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `pwm_in` input 1: asynchronous PWM input.
- `duty_out` output `DUTY_W`: measured duty code.
- `duty_valid` output 1: result available; held until accepted.
- `duty_ready` input 1: consumer accepts the result when `duty_valid && duty_ready`.
- `overrun` output 1: one-cycle pulse when an unaccepted result is overwritten.
- `stuck` output 1: high while the last result came from a timeout.

## Operation
- **Input conditioning.** `pwm_in` passes through a 2-flop synchronizer to give `s_in`, plus a delayed copy `s_prev`.
  - Rise: `s_in & ~s_prev`.
- **States.**
  - IDLE: counters are held. On a rise, load `per_cnt`=1 and `hi_cnt`=1, then go to MEAS.
  - MEAS: `per_cnt` increments every cycle. `hi_cnt` increments when `s_in`=1.
  - On the next rise in MEAS:
    - latch `per_cnt` and `hi_cnt` into the divider (start);
    - reload both counters to 1;
    - stay in MEAS.
  - Timeout: if `per_cnt` reaches 2^`CNT_W`-1 with no rise, post a result of all-ones (if `s_in`=1) or 0 (if `s_in`=0), set `stuck`, and go to IDLE.
  - `stuck` clears on the next divider result.
- **Arithmetic.** `duty` = floor(`hi` × 2^`DUTY_W` / `per`).
  - `hi` ≤ `per`-1, so the result never exceeds 2^`DUTY_W`-1 and no saturation is needed.
  - The divider is restoring, one quotient bit per cycle.
- **Minimum PWM period** is `DUTY_W`+2 cycles.
  - A rise that arrives while the divider is busy still reloads the counters, but its measurement is dropped.
  - No error flag is raised for a dropped measurement.
- **Output register.**
  - A new result loads `duty_out` and sets `duty_valid`.
  - A handshake clears `duty_valid`.
  - If a new result lands while `duty_valid`=1 and `duty_ready`=0: overwrite `duty_out`, pulse `overrun`, keep `duty_valid`=1.
  - If a new result and a handshake occur in the same cycle: the new value wins, `duty_valid` stays 1, no `overrun`.
- **Reset** (at any time, including mid-division or mid-period):
  - `duty_out`=0, `duty_valid`=0, `overrun`=0, `stuck`=0;
  - counters=0, divider idle, synchronizer flops=0, state=IDLE.
  - The first valid result therefore needs two rises after reset.

## Timing
- An edge on `pwm_in` is seen at `s_in` 2 `clk` edges later.
- `duty_valid` rises exactly `DUTY_W`+1 `clk` edges after the edge that latches the divider operands.
- A timeout result is posted on the edge after `per_cnt` reaches its maximum, with `duty_valid` asserted then.
- Steady state gives one result per PWM period.
- Measurement jitter is ±1 cycle, from synchronizer sampling.

## Configuration
- `CLK_TO_DUTY_CLAMP_EN` defined:
  - divider results are clamped to [`DUTY_LO`, `DUTY_HI`] before loading `duty_out`;
  - timeout results are clamped the same way.
- Undefined:
  - the raw quotient is output;
  - `DUTY_LO` and `DUTY_HI` are ignored.
  - No clamp logic is present.

## Structure
- Shared package `clk_to_duty_pkg` holds:
  - the state enum `{IDLE, MEAS}`;
  - the divider state enum `{DIV_IDLE, DIV_RUN}`;
  - default width constants `CNT_W_DEF` and `DUTY_W_DEF`.
- Sub-module `duty_div`:
  - sequential restoring divider;
  - `start`/`busy`/`done` handshake;
  - numerator is `hi` shifted left by `DUTY_W`, denominator is `per`;
  - produces a `DUTY_W`-bit quotient in `DUTY_W` cycles.
- Top level holds the synchronizer, counters, FSM, clamp and output register.

## Test plan
All cases use defaults unless stated.
- **25 % duty.** PWM period 1000 cycles, high 250, `duty_ready`=1 → `duty_out`=1024 on every result after the first two rises, one result per period, `overrun`=0.
- **Second operating point.** Period 400, high 100, then period 1000, high 500 → results 1024, then 2048 after one transition period.
- **Stuck high.** `pwm_in` held high for 70000 cycles → `duty_out`=4095, `stuck`=1, exactly one result. The next normal pulses (period 1000, high 250) give 1024 with `stuck`=0.
- **Backpressure.** `duty_ready`=0 across two periods (period 1000, high 300 then high 600) → `overrun` pulses once, `duty_out`=2457, `duty_valid` stays 1. Raising `duty_ready` clears it after one cycle.
- **Clamp.** Period 1000, high 20 → `duty_out`=205 with `CLK_TO_DUTY_CLAMP_EN`, 81 without it. Period 1000, high 950 → 3686 with the macro, 3891 without it.
- **Reset mid-operation.** `rst_n` pulsed low mid-division → all outputs 0 immediately. The first result appears `DUTY_W`+1 edges after the second post-reset rise.
